// File: rtl/hg_fetch_pkg.sv
// rtl/hg_fetch_pkg.sv - shared state type, RGB565 layout and defaults for the homography pixel fetcher
package hg_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_OUT,
        ST_GAP
    } fetch_state_t;

    localparam int RED_W   = 5;
    localparam int GREEN_W = 6;
    localparam int BLUE_W  = 5;
    localparam int PIX_W   = RED_W + GREEN_W + BLUE_W;

    localparam logic [PIX_W-1:0] DEF_FILL_COLOR   = 16'h0000;
    localparam int               DEF_FRAME_WIDTH  = 640;
    localparam int               DEF_FRAME_HEIGHT = 480;

    function automatic logic [PIX_W-1:0] pack_rgb(
        input logic [RED_W-1:0]   r,
        input logic [GREEN_W-1:0] g,
        input logic [BLUE_W-1:0]  b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/hg_req_pacer.sv
// rtl/hg_req_pacer.sv - counts request-low cycles after a fall; gap_ok once GAP_CYCLES have elapsed
module hg_req_pacer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic req,
    output logic gap_ok
);

    localparam int CW = $clog2(GAP_CYCLES + 1);

    logic [CW-1:0] gap_cnt_q, gap_cnt_d;

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (req) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != CW'(GAP_CYCLES)) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    // Preloaded satisfied so the first request after reset is not held off.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            gap_cnt_q <= CW'(GAP_CYCLES);
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign gap_ok = (gap_cnt_q == CW'(GAP_CYCLES));

endmodule

// File: rtl/hg_pixel_fetcher.sv
// rtl/hg_pixel_fetcher.sv - homography pixel-read initiator; FETCH_BOUNDS_CHECK_EN enables out-of-frame fill
module hg_pixel_fetcher
    import hg_fetch_pkg::*;
#(
    parameter int               FRAME_WIDTH   = DEF_FRAME_WIDTH,
    parameter int               FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
    parameter int               CAPTURE_DELAY = 4,
    parameter int               GAP_CYCLES    = 2,
    parameter logic [PIX_W-1:0] FILL_COLOR    = DEF_FILL_COLOR
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iReqValid,
    output logic               oReqReady,
    input  logic [9:0]         iSrcX,
    input  logic [9:0]         iSrcY,
    output logic               oPixValid,
    input  logic               iPixReady,
    output logic [RED_W-1:0]   oPixRed,
    output logic [GREEN_W-1:0] oPixGreen,
    output logic [BLUE_W-1:0]  oPixBlue,
    output logic               oPixMiss,
    output logic               oHGRequest,
    output logic [9:0]         oHGX,
    output logic [9:0]         oHGY,
    input  logic [RED_W-1:0]   iHGRed,
    input  logic [GREEN_W-1:0] iHGGreen,
    input  logic [BLUE_W-1:0]  iHGBlue,
    input  logic               iReady
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam int CNT_W = 4;

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             miss_q, miss_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             gap_ok;
    logic             oob;

    hg_req_pacer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_pacer (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .req   (req_q),
        .gap_ok(gap_ok)
    );

    assign oob = BOUNDS_EN && ((32'(iSrcX) >= FRAME_WIDTH) || (32'(iSrcY) >= FRAME_HEIGHT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        x_d     = x_q;
        y_d     = y_q;
        pix_d   = pix_q;
        miss_d  = miss_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (iReqValid && ready_q) begin
                    state_d = ST_REQ;
                    if (oob) begin
                        // Skip the frame store: jump straight to the release step.
                        cnt_d  = CNT_W'(CAPTURE_DELAY + 1);
                        pix_d  = FILL_COLOR;
                        miss_d = 1'b1;
                    end else begin
                        x_d   = iSrcX;
                        y_d   = iSrcY;
                        req_d = 1'b1;
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CAPTURE_DELAY)) begin
                    pix_d  = iReady ? pack_rgb(iHGRed, iHGGreen, iHGBlue) : FILL_COLOR;
                    miss_d = !iReady;
                end
                if (cnt_q == CNT_W'(CAPTURE_DELAY + 1)) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (iPixReady) begin
                    valid_d = 1'b0;
                    state_d = gap_ok ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE) && gap_ok;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            miss_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign oReqReady  = ready_q;
    assign oHGRequest = req_q;
    assign oHGX       = x_q;
    assign oHGY       = y_q;
    assign oPixValid  = valid_q;
    assign oPixMiss   = miss_q;
    assign oPixRed    = pix_q[PIX_W-1 -: RED_W];
    assign oPixGreen  = pix_q[BLUE_W +: GREEN_W];
    assign oPixBlue   = pix_q[BLUE_W-1:0];

endmodule

// File: tb/tb_hg_pixel_fetcher.sv
// tb/tb_hg_pixel_fetcher.sv - self-checking bench for hg_pixel_fetcher with a transaction-level model
module tb_hg_pixel_fetcher;

    localparam int          CD   = 4;
    localparam int          GAP  = 2;
    localparam int          FW   = 640;
    localparam int          FH   = 480;
    localparam logic [15:0] FILL = 16'h0000;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic       iCLK, iRST, iReqValid, oReqReady, oPixValid, iPixReady, oPixMiss;
    logic       oHGRequest, iReady;
    logic [9:0] iSrcX, iSrcY, oHGX, oHGY;
    logic [4:0] oPixRed, oPixBlue, iHGRed, iHGBlue;
    logic [5:0] oPixGreen, iHGGreen;
    logic [15:0] dut_pix;

    hg_pixel_fetcher dut (
        .iCLK(iCLK), .iRST(iRST), .iReqValid(iReqValid), .oReqReady(oReqReady),
        .iSrcX(iSrcX), .iSrcY(iSrcY), .oPixValid(oPixValid), .iPixReady(iPixReady),
        .oPixRed(oPixRed), .oPixGreen(oPixGreen), .oPixBlue(oPixBlue), .oPixMiss(oPixMiss),
        .oHGRequest(oHGRequest), .oHGX(oHGX), .oHGY(oHGY), .iHGRed(iHGRed),
        .iHGGreen(iHGGreen), .iHGBlue(iHGBlue), .iReady(iReady)
    );

    assign dut_pix = {oPixRed, oPixGreen, oPixBlue};

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pix;
        logic        miss;
        int          lat;
        bit          oob;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;

    exp_t        q[$];
    int          rdy_mode       = 1;
    int          pix_ready_mode = 1;
    bit          rgb_fixed_en   = 1'b0;
    logic [15:0] rgb_fixed      = 16'h0000;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rgb(input logic [9:0] x, input logic [9:0] y);
        if (rgb_fixed_en) return rgb_fixed;
        return ({6'b0, x} * 16'd37) ^ ({6'b0, y} * 16'd101) ^ 16'h5A3C;
    endfunction

    function automatic bit rdy_fn(input logic [9:0] x, input logic [9:0] y, input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return ((int'(x) + int'(y)) % 5) != 0;
    endfunction

    function automatic exp_t model(input logic [9:0] x, input logic [9:0] y, input int mode);
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.oob = BOUNDS && (int'(x) >= FW || int'(y) >= FH);
        e.lat = e.oob ? 1 : CD + 1;
        if (!e.oob && rdy_fn(x, y, mode)) begin
            e.pix  = mem_rgb(x, y);
            e.miss = 1'b0;
        end else begin
            e.pix  = FILL;
            e.miss = 1'b1;
        end
        return e;
    endfunction

    // Compare process: runs 1 time unit after each falling edge.
    int          cyc = 0;
    int          acc_cyc = 0;
    int          low_cnt = 1000;
    bit          p_acc = 1'b0;
    logic [9:0]  p_x, p_y;
    int          p_mode;
    logic        prev_valid = 1'b0, prev_pready = 1'b0, prev_req = 1'b0, prev_miss = 1'b0;
    logic [15:0] prev_pix = '0;
    logic [9:0]  prev_x = '0, prev_y = '0;

    initial begin
        iReady = 1'b0;
        {iHGRed, iHGGreen, iHGBlue} = 16'h0;
        forever begin
            @(negedge iCLK);
            #1;
            cyc++;
            if (!iRST) begin
                chk(!oHGRequest && !oPixValid && !oPixMiss && !oReqReady && dut_pix == 16'h0
                    && oHGX == 10'h0 && oHGY == 10'h0, "reset_outputs",
                    {28'h0, oHGRequest, oPixValid, oReqReady, oPixMiss}, 32'h0);
                q.delete();
                p_acc = 1'b0; prev_valid = 1'b0; prev_pready = 1'b0; prev_req = 1'b0;
                prev_pix = '0; prev_miss = 1'b0; prev_x = '0; prev_y = '0; low_cnt = 1000;
            end else begin
                if (p_acc) begin
                    q.push_back(model(p_x, p_y, p_mode));
                    acc_cyc = cyc;
                end
                if (oPixValid && !prev_valid) begin
                    if (q.size() > 0) chk(cyc - acc_cyc == q[0].lat, "valid_latency", 32'(cyc - acc_cyc), 32'(q[0].lat));
                    else chk(1'b0, "valid_without_request", 32'(oPixValid), 32'h0);
                end
                if (oHGRequest && !prev_req) begin
                    chk(low_cnt >= GAP, "request_gap", 32'(low_cnt), 32'(GAP));
                    chk(q.size() == 1 && !q[0].oob && cyc == acc_cyc, "request_rise", 32'(q.size()), 32'h1);
                    if (q.size() > 0) chk(oHGX == q[0].x && oHGY == q[0].y, "request_xy", {12'h0, oHGX, oHGY}, {12'h0, q[0].x, q[0].y});
                end else begin
                    chk(oHGX == prev_x && oHGY == prev_y, "xy_hold", {12'h0, oHGX, oHGY}, {12'h0, prev_x, prev_y});
                end
                if (prev_valid && !prev_pready) begin
                    chk(oPixValid && dut_pix == prev_pix && oPixMiss == prev_miss, "pix_hold",
                        {15'h0, oPixValid, dut_pix}, {15'h1, prev_pix});
                end
                if (oHGRequest || oPixValid) begin
                    chk(!oReqReady && !(oHGRequest && oPixValid), "no_overlap",
                        {30'h0, oReqReady, oHGRequest && oPixValid}, 32'h0);
                end
                if (oPixValid && iPixReady) begin
                    if (q.size() > 0) begin
                        chk(dut_pix == q[0].pix && oPixMiss == q[0].miss, "pixel",
                            {15'h0, oPixMiss, dut_pix}, {15'h0, q[0].miss, q[0].pix});
                        void'(q.pop_front());
                    end else begin
                        chk(1'b0, "unexpected_pixel", {16'h0, dut_pix}, 32'h0);
                    end
                end
                low_cnt     = oHGRequest ? 0 : low_cnt + 1;
                prev_valid  = oPixValid;
                prev_pready = iPixReady;
                prev_req    = oHGRequest;
                prev_pix    = dut_pix;
                prev_miss   = oPixMiss;
                prev_x      = oHGX;
                prev_y      = oHGY;
                p_acc       = iReqValid && oReqReady;
                p_x         = iSrcX;
                p_y         = iSrcY;
                p_mode      = rdy_mode;
            end
            // Frame-store responder: data window only while a request is high.
            if (oHGRequest && rdy_fn(oHGX, oHGY, rdy_mode)) begin
                iReady = 1'b1;
                {iHGRed, iHGGreen, iHGBlue} = mem_rgb(oHGX, oHGY);
            end else begin
                iReady = 1'b0;
                {iHGRed, iHGGreen, iHGBlue} = 16'($urandom);
            end
        end
    end

    initial begin
        iPixReady = 1'b1;
        forever begin
            @(negedge iCLK);
            case (pix_ready_mode)
                0:       iPixReady = ($urandom_range(0, 9) < 7);
                1:       iPixReady = 1'b1;
                default: iPixReady = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [9:0] x, input logic [9:0] y, input bit keep);
        bit hs;
        hs = 1'b0;
        iSrcX = x;
        iSrcY = y;
        iReqValid = 1'b1;
        for (int k = 0; k < 300 && !hs; k++) begin
            hs = oReqReady;
            @(negedge iCLK);
        end
        if (!hs) chk(1'b0, "accept_timeout", 32'(hs), 32'h1);
        if (!keep) iReqValid = 1'b0;
    endtask

    task automatic expect_pix(input logic [15:0] p, input logic m, input int lat, input string nm);
        int k;
        k = 0;
        while (!oPixValid && k < 50) begin
            @(negedge iCLK);
            k++;
        end
        chk(k == lat, {nm, "_latency"}, 32'(k), 32'(lat));
        chk(dut_pix == p, {nm, "_pix"}, {16'h0, dut_pix}, {16'h0, p});
        chk(oPixMiss == m, {nm, "_miss"}, 32'(oPixMiss), 32'(m));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge iCLK);
        while ((q.size() != 0 || oPixValid || oHGRequest) && k < 300) begin
            @(negedge iCLK);
            k++;
        end
        if (k >= 300) chk(1'b0, "idle_timeout", 32'(q.size()), 32'h0);
    endtask

    task automatic directed_basic();
        rdy_mode = 1;
        rgb_fixed_en = 1'b1;
        rgb_fixed = 16'hF81F;
        send(10'd10, 10'd20, 1'b0);
        chk(oHGRequest && oHGX == 10'd10 && oHGY == 10'd20, "t1_request",
            {11'h0, oHGRequest, oHGX, oHGY}, {11'h1, 10'd10, 10'd20});
        expect_pix(16'hF81F, 1'b0, 5, "t1");
        wait_idle();
        rgb_fixed_en = 1'b0;
    endtask

    initial begin
        iRST = 1'b1;
        iReqValid = 1'b0;
        iSrcX = '0;
        iSrcY = '0;
        #1 iRST = 1'b0;
        repeat (4) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);

        directed_basic();

        rdy_mode = 2;
        send(10'd5, 10'd5, 1'b0);
        expect_pix(16'h0000, 1'b1, 5, "t2");
        chk(!oHGRequest, "t2_request_low", 32'(oHGRequest), 32'h0);
        wait_idle();

        rdy_mode = 1;
        pix_ready_mode = 2;
        send(10'd30, 10'd40, 1'b0);
        expect_pix(mem_rgb(10'd30, 10'd40), 1'b0, 5, "t3");
        iSrcX = 10'd50;
        iSrcY = 10'd60;
        iReqValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            chk(oPixValid && !oReqReady && !oHGRequest, "t3_backpressure",
                {29'h0, oPixValid, oReqReady, oHGRequest}, 32'h4);
        end
        pix_ready_mode = 1;
        send(10'd50, 10'd60, 1'b0);
        wait_idle();

        rdy_mode = 0;
        send(10'd1, 10'd2, 1'b1);
        send(10'd3, 10'd4, 1'b1);
        send(10'd600, 10'd400, 1'b0);
        wait_idle();

        rdy_mode = 1;
        send(10'd100, 10'd100, 1'b0);
        @(negedge iCLK);
        iRST = 1'b0;
        #2;
        chk(!oHGRequest && !oPixValid, "t5_reset_drop", {30'h0, oHGRequest, oPixValid}, 32'h0);
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        directed_basic();

`ifdef FETCH_BOUNDS_CHECK_EN
        rdy_mode = 1;
        send(10'd640, 10'd0, 1'b0);
        chk(!oHGRequest, "t6_no_request", 32'(oHGRequest), 32'h0);
        expect_pix(16'h0000, 1'b1, 1, "t6");
        wait_idle();
        send(10'd639, 10'd479, 1'b0);
        chk(oHGRequest && oHGX == 10'd639 && oHGY == 10'd479, "t6_edge_request",
            {11'h0, oHGRequest, oHGX, oHGY}, {11'h1, 10'd639, 10'd479});
        expect_pix(mem_rgb(10'd639, 10'd479), 1'b0, 5, "t6b");
        wait_idle();
`endif

        rdy_mode = 0;
        pix_ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            logic [9:0] rx, ry;
            if ($urandom_range(0, 3) == 0) begin
                rx = 10'($urandom_range(0, 1023));
                ry = 10'($urandom_range(0, 1023));
            end else begin
                rx = 10'($urandom_range(0, FW - 1));
                ry = 10'($urandom_range(0, FH - 1));
            end
            send(rx, ry, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
        end
        iReqValid = 1'b0;
        pix_ready_mode = 1;
        wait_idle();
        chk(q.size() == 0, "drain", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
